pn_spreader_param: RTL
======================

Name: pn_spreader_param

Overview:
- Parametrised successor to the HLS spreader / pn_seq_gen_lfsr pair.
- Contains its own configurable-order LFSR chip generator, a spreading factor and two modes. No external PN handshake or load feedback is needed.
- Sits between axi_wrapper m_axis_data and s_axis_data in the channel-sounder noc_block. Operates on SC16 samples: I in [31:16], Q in [15:0].

Parameters:
- MAX_ORDER, 16: LFSR register width; maximum polynomial order.
- LEN_W, 16: width of the sequence-length and chip counters.
- SF_W, 8: width of the spreading-factor field.
- RESTART_ON_TLAST, 1: when 1, the LFSR reloads its seed after each output tlast beat.

Ports:
- ap_clk, in, 1: single clock. All logic runs on ap_clk.
- ap_rst_n, in, 1: reset. Asynchronous, active-low.
- cfg_poly, in, MAX_ORDER: feedback tap mask.
- cfg_seed, in, MAX_ORDER: LFSR seed.
- cfg_order, in, 5: active order, legal range 2..MAX_ORDER.
- cfg_len, in, LEN_W: chips per period; 0 means free-run with no reload.
- cfg_sf, in, SF_W: chips per input sample in mode 0; 0 is treated as 1.
- cfg_mode, in, 1: 0 = spread (each input sample emitted sf times); 1 = scramble (one chip per sample).
- cfg_load, in, 1: strobe that latches all cfg_* fields.
- i_data_tdata, in, 32: input SC16 sample.
- i_data_tvalid, in, 1: input valid.
- i_data_tlast, in, 1: input end of packet.
- i_data_tready, out, 1: input ready.
- o_data_tdata, out, 32: output SC16 sample.
- o_data_tvalid, out, 1: output valid.
- o_data_tlast, out, 1: output end of packet.
- o_data_tready, in, 1: output ready.
- busy, out, 1: high while in RUN with a sample partially emitted.
- period_cnt, out, 16: number of completed PN periods; wraps at 16 bits.

Behaviour:
- Reset values: o_data_tvalid=0, o_data_tdata=0, o_data_tlast=0, i_data_tready=0, busy=0, period_cnt=0. Active cfg register cleared; state=IDLE.
- States:
  - IDLE: waits for the first cfg_load, then goes to LOAD.
  - LOAD: lfsr<=cfg_seed masked to cfg_order bits; chip_cnt<=0; rep_cnt<=0; goes to RUN in 1 cycle.
  - RUN: normal operation.
- cfg_load while in RUN:
  - At a sample boundary (rep_cnt==0 and no sample held): new config applies via LOAD next cycle.
  - Otherwise: a pending flag is set and LOAD is entered after the last chip of the current sample is accepted.
  - A second cfg_load while pending overwrites the staged values.
- LFSR (Fibonacci form):
  - chip = lfsr[0]; fb = XOR-reduction of (lfsr & cfg_poly & order_mask).
  - next[i] = lfsr[i+1] for i < order-1; next[order-1] = fb; bits at or above order stay 0.
  - Advances exactly once per output beat accepted (o_data_tvalid & o_data_tready).
- Period handling:
  - chip_cnt increments per accepted beat.
  - If cfg_len != 0 and chip_cnt == cfg_len-1 on an accepted beat: lfsr<=seed, chip_cnt<=0, period_cnt+1.
  - If RESTART_ON_TLAST=1 and the accepted beat has tlast: same reload, and period_cnt is NOT incremented unless the period also completed on that beat.
  - Simultaneous period end and tlast: a single reload and a single period_cnt increment.
- Arithmetic per component:
  - chip 1 gives out = x.
  - chip 0 gives out = -x, saturated so that -(-32768) = 32767 (0x8000 becomes 0x7FFF).
- Handshake:
  - A single output register holds the current input sample.
  - i_data_tready = RUN & no held sample & (!o_data_tvalid | o_data_tready) & !pending.
  - Mode 0: the held sample is emitted sf times, each beat with the current chip. It is released after beat rep_cnt == sf-1.
  - Mode 1: each sample is emitted once.
  - Latency from input accept to the first output beat is 1 cycle.
  - Full throughput in mode 1 with o_data_tready held high.
  - o_data_tdata and o_data_tvalid stay stable while tvalid & !tready (AXI-Stream rule).
- tlast: mode 0 asserts it only on the last of the sf beats of a tlast input; mode 1 passes it through.
- cfg_order outside 2..MAX_ORDER is clamped into that range.
- An all-zero seed gives a constant chip of 0; this is legal and not corrected.
- Reset mid-packet: all outputs return to reset values immediately (asynchronous), and the block requires a new cfg_load.

Test Plan:
- Expected chip sequence for all cases below: order=3, poly=0x3, seed=0x1 gives chips 1,0,0,1,0,1,1 (period 7).
- Mode 1 with cfg_len=7: seven inputs of 0x01000200 -> outputs 01000200, FF00FE00, FF00FE00, 01000200, FF00FE00, 01000200, 01000200. period_cnt=1; the 8th output is 01000200.
- Mode 0 with sf=3: a single input 0x00010001 with tlast -> 3 beats, +, -, -; tlast only on beat 3. The next packet restarts at chip 1 (RESTART_ON_TLAST=1).
- Saturation: input 0x80008000 on chip 0 -> output 0x7FFF7FFF; on chip 1 -> 0x80008000.
- Backpressure: mode 0, sf=2, o_data_tready toggled 1,0,0,1 -> data held stable while stalled; LFSR advances only on accepted beats; no input accepted until both beats are accepted.
- cfg_load at beat 1 of an sf=4 sample: the remaining 3 beats use the old sequence; the next sample starts from the new seed after a 1-cycle LOAD gap. Deasserting ap_rst_n mid-stream -> tvalid=0 asynchronously, period_cnt=0.

Source files
------------

// File: rtl/pn_spreader_param.sv
// pn_spreader_param: spreads or scrambles SC16 samples with an internally generated PN chip stream.
//
// A configurable-order Fibonacci LFSR produces one chip per accepted output beat. In mode 0 each
// input sample is repeated sf times with the current chip applied to each repeat. In mode 1 each
// sample is emitted once. Chip 1 passes a component through unchanged. Chip 0 negates it, with
// saturation.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   cfg_*                     configuration, latched on the cfg_load strobe
//   i_data_*                  AXI-Stream input, SC16 (I in [31:16], Q in [15:0])
//   o_data_*                  AXI-Stream output, SC16
//   busy                      RUN with a sample partially emitted
//   period_cnt                completed PN periods, wraps at 16 bits
module pn_spreader_param #(
   parameter int unsigned MAX_ORDER        = 16,
   parameter int unsigned LEN_W            = 16,
   parameter int unsigned SF_W             = 8,
   parameter bit          RESTART_ON_TLAST = 1'b1
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [MAX_ORDER-1:0] cfg_poly,
   input  logic [MAX_ORDER-1:0] cfg_seed,
   input  logic [4:0]           cfg_order,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic [SF_W-1:0]      cfg_sf,
   input  logic                 cfg_mode,
   input  logic                 cfg_load,
   input  logic [31:0]          i_data_tdata,
   input  logic                 i_data_tvalid,
   input  logic                 i_data_tlast,
   output logic                 i_data_tready,
   output logic [31:0]          o_data_tdata,
   output logic                 o_data_tvalid,
   output logic                 o_data_tlast,
   input  logic                 o_data_tready,
   output logic                 busy,
   output logic [15:0]          period_cnt
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   function automatic logic [4:0] clamp_order(input logic [4:0] ord);
      if (ord < 5'd2) return 5'd2;
      if (32'(ord) > MAX_ORDER) return 5'(MAX_ORDER);
      return ord;
   endfunction

   function automatic logic [MAX_ORDER-1:0] order_mask(input logic [4:0] ord);
      logic [MAX_ORDER-1:0] m;
      m = '0;
      for (int i = 0; i < int'(MAX_ORDER); i++) m[i] = (i < int'(ord));
      return m;
   endfunction

   // Negation with the single overflow case (-32768) pinned to +32767.
   function automatic logic [15:0] neg_sat(input logic [15:0] x);
      return (x == 16'h8000) ? 16'h7fff : (16'h0000 - x);
   endfunction

   state_e               state_q, state_d;
   // Staged configuration, captured on every cfg_load and applied in LOAD.
   logic [MAX_ORDER-1:0] stg_poly_q, stg_poly_d, stg_seed_q, stg_seed_d;
   logic [4:0]           stg_order_q, stg_order_d;
   logic [LEN_W-1:0]     stg_len_q, stg_len_d;
   logic [SF_W-1:0]      stg_sf_q, stg_sf_d;
   logic                 stg_mode_q, stg_mode_d;
   // Active configuration.
   logic [MAX_ORDER-1:0] poly_q, poly_d, seed_q, seed_d;
   logic [4:0]           order_q, order_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [SF_W-1:0]      sf_q, sf_d;
   logic                 mode_q, mode_d;

   logic                 pending_q, pending_d;
   logic [MAX_ORDER-1:0] lfsr_q, lfsr_d;
   logic [LEN_W-1:0]     chip_cnt_q, chip_cnt_d;
   logic [SF_W-1:0]      rep_cnt_q, rep_cnt_d;
   logic [15:0]          period_cnt_q, period_cnt_d;
   logic                 held_q, held_d, hold_last_q, hold_last_d;
   logic [31:0]          hold_data_q, hold_data_d;

   logic [MAX_ORDER-1:0] act_mask, lfsr_shr, lfsr_step;
   logic [4:0]           cfg_order_cl;
   logic [SF_W-1:0]      sf_eff;
   logic                 fb, chip, last_rep, beat, sample_done, at_boundary, in_acc, period_end;

   assign cfg_order_cl = clamp_order(cfg_order);
   assign act_mask     = order_mask(order_q);
   assign sf_eff       = (sf_q == '0) ? SF_W'(1) : sf_q;
   assign last_rep     = mode_q | (rep_cnt_q == sf_eff - SF_W'(1));
   assign beat         = held_q & o_data_tready;
   assign sample_done  = beat & last_rep;
   assign at_boundary  = ~held_q & (rep_cnt_q == '0);
   assign period_end   = (len_q != '0) & (chip_cnt_q == len_q - LEN_W'(1));
   assign chip         = lfsr_q[0];

   // The held sample is released on the same edge that accepts its last beat, so a new sample
   // can be taken without a bubble. cfg_load blocks acceptance so a reload never races a sample.
   assign i_data_tready = (state_q == StRun) & ~pending_q & ~cfg_load & (~held_q | sample_done);
   assign in_acc        = i_data_tvalid & i_data_tready;

   assign o_data_tvalid = held_q;
   assign o_data_tlast  = held_q & hold_last_q & last_rep;
   assign o_data_tdata  = ~held_q ? 32'h0 :
                          chip    ? hold_data_q :
                                    {neg_sat(hold_data_q[31:16]), neg_sat(hold_data_q[15:0])};
   assign busy          = (state_q == StRun) & held_q & (rep_cnt_q != '0);
   assign period_cnt    = period_cnt_q;

   // Fibonacci step: shift down, feedback enters at bit order-1, bits above stay clear.
   always_comb begin
      fb        = ^(lfsr_q & poly_q & act_mask);
      lfsr_shr  = lfsr_q >> 1;
      lfsr_step = '0;
      for (int i = 0; i < int'(MAX_ORDER); i++) begin
         if (i + 1 < int'(order_q))       lfsr_step[i] = lfsr_shr[i];
         else if (i + 1 == int'(order_q)) lfsr_step[i] = fb;
      end
   end

   always_comb begin
      state_d      = state_q;
      stg_poly_d   = stg_poly_q;
      stg_seed_d   = stg_seed_q;
      stg_order_d  = stg_order_q;
      stg_len_d    = stg_len_q;
      stg_sf_d     = stg_sf_q;
      stg_mode_d   = stg_mode_q;
      poly_d       = poly_q;
      seed_d       = seed_q;
      order_d      = order_q;
      len_d        = len_q;
      sf_d         = sf_q;
      mode_d       = mode_q;
      pending_d    = pending_q;
      lfsr_d       = lfsr_q;
      chip_cnt_d   = chip_cnt_q;
      rep_cnt_d    = rep_cnt_q;
      period_cnt_d = period_cnt_q;
      held_d       = held_q;
      hold_last_d  = hold_last_q;
      hold_data_d  = hold_data_q;

      if (cfg_load) begin
         stg_poly_d  = cfg_poly;
         stg_seed_d  = cfg_seed & order_mask(cfg_order_cl);
         stg_order_d = cfg_order_cl;
         stg_len_d   = cfg_len;
         stg_sf_d    = cfg_sf;
         stg_mode_d  = cfg_mode;
      end

      unique case (state_q)
         StIdle: begin
            if (cfg_load) state_d = StLoad;
         end
         StLoad: begin
            // A load strobe landing here is applied on the following LOAD cycle.
            if (!cfg_load) begin
               poly_d     = stg_poly_q;
               seed_d     = stg_seed_q;
               order_d    = stg_order_q;
               len_d      = stg_len_q;
               sf_d       = stg_sf_q;
               mode_d     = stg_mode_q;
               lfsr_d     = stg_seed_q;
               chip_cnt_d = '0;
               rep_cnt_d  = '0;
               state_d    = StRun;
            end
         end
         StRun: begin
            if (beat) begin
               lfsr_d     = lfsr_step;
               chip_cnt_d = chip_cnt_q + LEN_W'(1);
               if (period_end) period_cnt_d = period_cnt_q + 16'd1;
               if (period_end || (RESTART_ON_TLAST && o_data_tlast)) begin
                  lfsr_d     = seed_q;
                  chip_cnt_d = '0;
               end
               rep_cnt_d = last_rep ? '0 : rep_cnt_q + SF_W'(1);
            end
            if (in_acc) begin
               held_d      = 1'b1;
               hold_data_d = i_data_tdata;
               hold_last_d = i_data_tlast;
            end else if (sample_done) begin
               held_d = 1'b0;
            end
            if (cfg_load) begin
               if (at_boundary || sample_done) begin
                  state_d   = StLoad;
                  pending_d = 1'b0;
               end else begin
                  pending_d = 1'b1;
               end
            end else if (pending_q && (sample_done || !held_q)) begin
               state_d   = StLoad;
               pending_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q      <= StIdle;
         stg_poly_q   <= '0;
         stg_seed_q   <= '0;
         stg_order_q  <= '0;
         stg_len_q    <= '0;
         stg_sf_q     <= '0;
         stg_mode_q   <= 1'b0;
         poly_q       <= '0;
         seed_q       <= '0;
         order_q      <= '0;
         len_q        <= '0;
         sf_q         <= '0;
         mode_q       <= 1'b0;
         pending_q    <= 1'b0;
         lfsr_q       <= '0;
         chip_cnt_q   <= '0;
         rep_cnt_q    <= '0;
         period_cnt_q <= '0;
         held_q       <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         stg_poly_q   <= stg_poly_d;
         stg_seed_q   <= stg_seed_d;
         stg_order_q  <= stg_order_d;
         stg_len_q    <= stg_len_d;
         stg_sf_q     <= stg_sf_d;
         stg_mode_q   <= stg_mode_d;
         poly_q       <= poly_d;
         seed_q       <= seed_d;
         order_q      <= order_d;
         len_q        <= len_d;
         sf_q         <= sf_d;
         mode_q       <= mode_d;
         pending_q    <= pending_d;
         lfsr_q       <= lfsr_d;
         chip_cnt_q   <= chip_cnt_d;
         rep_cnt_q    <= rep_cnt_d;
         period_cnt_q <= period_cnt_d;
         held_q       <= held_d;
         hold_last_q  <= hold_last_d;
         hold_data_q  <= hold_data_d;
      end
   end

endmodule
